// File: rtl/tile_mac_feeder_pkg.sv
// Shared types and widths for the tile MAC feeder: FSM encoding, default
// datapath widths and the signed product width helper.
package tile_mac_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int unsigned IN_WIDTH_DEF   = 16;
  localparam int unsigned TILE_LEN_DEF   = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 64;
  localparam int unsigned TCNT_WIDTH_DEF = 8;

  // Full width of a signed IN_WIDTH x IN_WIDTH product.
  function automatic int unsigned prod_width(input int unsigned in_width);
    return 2 * in_width;
  endfunction

endpackage

// File: rtl/tile_mac_feeder_mac_unit.sv
// Signed multiply plus running partial sum; the partial drops to zero when
// clear is asserted (tile boundary or row start).
module tile_mac_unit
  import tile_mac_feeder_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_en,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  in_a,
  input  logic [IN_WIDTH-1:0]  in_b,
  output logic [ACC_WIDTH-1:0] sum_next
);

  localparam int unsigned PW = prod_width(IN_WIDTH);

  logic signed [PW-1:0] product;
  logic [ACC_WIDTH-1:0] product_ext;
  logic [ACC_WIDTH-1:0] partial_q, partial_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    product     = $signed(in_a) * $signed(in_b);
    product_ext = {{(ACC_WIDTH - PW){product[PW-1]}}, product};
    sum_next    = partial_q + product_ext;
    partial_d   = partial_q;
    if (clear) begin
      partial_d = '0;
    end else if (acc_en) begin
      partial_d = sum_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial_q <= '0;
    end else begin
      partial_q <= partial_d;
    end
  end

endmodule

// File: rtl/tile_mac_feeder.sv
// Streams (a, b) pairs into TILE_LEN-long dot products, pulses each tile sum,
// clears the downstream accumulator at row start and flags row completion.
module tile_mac_feeder
  import tile_mac_feeder_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = IN_WIDTH_DEF,
  parameter int unsigned TILE_LEN   = TILE_LEN_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned TCNT_WIDTH = TCNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  row_start,
  input  logic [TCNT_WIDTH-1:0] num_tiles,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_a,
  input  logic [IN_WIDTH-1:0]   in_b,
  output logic                  acc_clear,
  output logic                  tile_valid,
  output logic [ACC_WIDTH-1:0]  tile_sum,
  output logic                  row_done,
  output logic                  busy
);

  localparam int unsigned ELEM_W = $clog2(TILE_LEN);
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(TILE_LEN - 1);

  state_e                 state_q, state_d;
  logic [TCNT_WIDTH-1:0]  num_tiles_q, num_tiles_d;
  logic [TCNT_WIDTH-1:0]  tile_cnt_q, tile_cnt_d;
  logic [ELEM_W-1:0]      elem_cnt_q, elem_cnt_d;
  logic                   tile_valid_q, tile_valid_d;
  logic                   row_done_q, row_done_d;
  logic [ACC_WIDTH-1:0]   tile_sum_q, tile_sum_d;

  logic                   accept;
  logic                   tile_end;
  logic                   last_tile;
  logic [ACC_WIDTH-1:0]   sum_next;

  assign in_ready  = (state_q == ST_RUN);
  assign acc_clear = (state_q == ST_CLEAR);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = in_ready & in_valid;
  assign tile_end  = accept && (elem_cnt_q == LAST_ELEM);
  assign last_tile = (tile_cnt_q == num_tiles_q - TCNT_WIDTH'(1));

  assign tile_valid = tile_valid_q;
  assign tile_sum   = tile_sum_q;
  assign row_done   = row_done_q;

  // Partial is cleared at row start too, so an aborted row can never leak in.
  tile_mac_unit #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_en   (accept),
    .clear    (tile_end | acc_clear),
    .in_a     (in_a),
    .in_b     (in_b),
    .sum_next (sum_next)
  );

  always_comb begin
    state_d      = state_q;
    num_tiles_d  = num_tiles_q;
    tile_cnt_d   = tile_cnt_q;
    elem_cnt_d   = elem_cnt_q;
    tile_sum_d   = tile_sum_q;
    tile_valid_d = 1'b0;
    row_done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (row_start) begin
          num_tiles_d = num_tiles;
          tile_cnt_d  = '0;
          elem_cnt_d  = '0;
          state_d     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (num_tiles_q == '0) begin
          state_d    = ST_IDLE;
          row_done_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          elem_cnt_d = elem_cnt_q + ELEM_W'(1);
          if (tile_end) begin
            elem_cnt_d   = '0;
            tile_cnt_d   = tile_cnt_q + TCNT_WIDTH'(1);
            tile_sum_d   = sum_next;
            tile_valid_d = 1'b1;
            if (last_tile) begin
              state_d    = ST_IDLE;
              row_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_tiles_q  <= '0;
      tile_cnt_q   <= '0;
      elem_cnt_q   <= '0;
      tile_sum_q   <= '0;
      tile_valid_q <= 1'b0;
      row_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_tiles_q  <= num_tiles_d;
      tile_cnt_q   <= tile_cnt_d;
      elem_cnt_q   <= elem_cnt_d;
      tile_sum_q   <= tile_sum_d;
      tile_valid_q <= tile_valid_d;
      row_done_q   <= row_done_d;
    end
  end

endmodule

// File: tb/tb_tile_mac_feeder.sv
// Bench for tile_mac_feeder: rows of operand pairs are checked against a
// list-of-products reference model, cycle by cycle, sampled on negedge.
module tb_tile_mac_feeder;

  localparam int IN_WIDTH   = 16;
  localparam int TILE_LEN   = 8;
  localparam int ACC_WIDTH  = 64;
  localparam int TCNT_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  row_start;
  logic [TCNT_WIDTH-1:0] num_tiles;
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_a;
  logic [IN_WIDTH-1:0]   in_b;
  logic                  acc_clear;
  logic                  tile_valid;
  logic [ACC_WIDTH-1:0]  tile_sum;
  logic                  row_done;
  logic                  busy;

  int vectors     = 0;
  int miscompares = 0;

  tile_mac_feeder #(
    .IN_WIDTH   (IN_WIDTH),
    .TILE_LEN   (TILE_LEN),
    .ACC_WIDTH  (ACC_WIDTH),
    .TCNT_WIDTH (TCNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_start  (row_start),
    .num_tiles  (num_tiles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .acc_clear  (acc_clear),
    .tile_valid (tile_valid),
    .tile_sum   (tile_sum),
    .row_done   (row_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint observed, input longint expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_acc_clear"},  acc_clear,  0);
    check({tag, "_tile_valid"}, tile_valid, 0);
    check({tag, "_tile_sum"},   tile_sum,   0);
    check({tag, "_row_done"},   row_done,   0);
    check({tag, "_busy"},       busy,       0);
  endtask

  // Operand generators. mode 0: a=1..8,b=1; 1: signed pair per tile;
  // 2: a=2,b=3; 3: random full range; 4: a=b=1.
  task automatic gen_ops(input int mode, input int idx, output int ai, output int bi);
    int t;
    int e;
    t = idx / TILE_LEN;
    e = idx % TILE_LEN;
    case (mode)
      0: begin ai = e + 1; bi = 1; end
      1: begin
        ai = (t == 0) ? -3 : -32768;
        bi = (t == 0) ?  5 : -32768;
      end
      2: begin ai = 2; bi = 3; end
      3: begin
        ai = int'($signed(16'($urandom)));
        bi = int'($signed(16'($urandom)));
      end
      default: begin ai = 1; bi = 1; end
    endcase
  endtask

  // One row: abort_after >= 0 pulls reset after that many accepted pairs.
  task automatic run_row(input int ntiles, input int mode, input int bubble_pct,
                         input bit poke_start, input int abort_after);
    longint exp_q[$];
    longint cur = 0;
    int     n_acc = 0;
    int     total;
    int     ai;
    int     bi;
    bit     pend = 0;
    bit     poked = 0;
    bit     finished = 0;
    bit     exp_tv;
    total = ntiles * TILE_LEN;

    @(negedge clk);
    row_start = 1'b1;
    num_tiles = TCNT_WIDTH'(ntiles);
    in_valid  = 1'b0;
    @(negedge clk);
    row_start = 1'b0;
    num_tiles = 8'($urandom);
    check("clear_pulse", acc_clear, 1);
    check("clear_ready", in_ready, 0);
    check("clear_busy",  busy, 1);

    if (ntiles == 0) begin
      @(negedge clk);
      check("zero_row_done",   row_done, 1);
      check("zero_tile_valid", tile_valid, 0);
      check("zero_ready",      in_ready, 0);
      check("zero_busy",       busy, 0);
      @(negedge clk);
      check("zero_done_once",  row_done, 0);
      check("zero_no_clear",   acc_clear, 0);
      return;
    end

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (pend) n_acc++;
      exp_tv = pend && (n_acc % TILE_LEN == 0);
      check("tile_valid", tile_valid, exp_tv);
      check("row_done",   row_done, exp_tv && (n_acc == total));
      if (exp_tv) check("tile_sum", tile_sum, exp_q.pop_front());
      if (cyc > 0) check("acc_clear", acc_clear, 0);
      check("in_ready", in_ready, (cyc > 0) && (n_acc < total));
      check("busy",     busy, n_acc < total);
      pend = 1'b0;

      if (n_acc == total) begin
        finished = 1'b1;
      end else if (abort_after >= 0 && n_acc == abort_after) begin
        in_valid  = 1'b0;
        row_start = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        check_all_zero("abort_hold");
        rst_n = 1'b1;
        return;
      end else begin
        row_start = poke_start && (n_acc == 3) && !poked;
        if (row_start) begin
          poked     = 1'b1;
          num_tiles = TCNT_WIDTH'(ntiles + 3);
        end
        in_valid = ($urandom_range(99) >= bubble_pct);
        gen_ops(mode, n_acc, ai, bi);
        in_a = IN_WIDTH'(ai);
        in_b = IN_WIDTH'(bi);
        if (in_valid && cyc > 0) begin
          pend = 1'b1;
          cur += longint'(ai) * longint'(bi);
          if ((n_acc + 1) % TILE_LEN == 0) begin
            exp_q.push_back(cur);
            cur = 0;
          end
        end
        @(negedge clk);
      end
    end
    if (!finished) check("row_timeout", 0, 1);
    in_valid  = 1'b0;
    row_start = 1'b0;
    @(negedge clk);
    check("idle_busy",     busy, 0);
    check("idle_clear",    acc_clear, 0);
    check("idle_ready",    in_ready, 0);
    check("idle_row_done", row_done, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    row_start = 1'b0;
    num_tiles = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_row(1, 0, 0,  1'b0, -1);   // basic tile, sum 36
    run_row(2, 1, 0,  1'b0, -1);   // signed, -120 then 2^33
    run_row(3, 2, 50, 1'b0, -1);   // bubbles, 48 per tile
    run_row(0, 0, 0,  1'b0, -1);   // empty row
    run_row(2, 3, 30, 1'b1, -1);   // ignored mid-row start
    run_row(1, 4, 0,  1'b0, 5);    // reset after 5 pairs
    run_row(1, 4, 0,  1'b0, -1);   // clean row, sum 8
    run_row(4, 3, 25, 1'b0, -1);   // random full-range row

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
